pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_seq_pkg.sv | 36 +++
 rtl/sync_ff_chain.sv | 39 +++
 rtl/pll_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// ============================================================================
// Module      : pll_reset_seq_pkg
// Description : Shared state encoding and counter-width helper for the
//               PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_reset_seq_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states; encoding is fixed so it can be probed externally.
    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    // Width able to hold the larger of the two interval lengths,
    // i.e. clog2(max(lock_cycles, reset_cycles) + 1).
    function automatic int cnt_width(input int lock_cycles, input int reset_cycles);
        int max_v;
        int w;
        max_v = (lock_cycles > reset_cycles) ? lock_cycles : reset_cycles;
        w     = 1;
        while ((1 << w) < (max_v + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : pll_reset_seq_pkg

`default_nettype wire

// File: rtl/sync_ff_chain.sv
// ============================================================================
// Module      : sync_ff_chain
// Description : Single-bit multi-flop synchronizer with asynchronous
//               active-low clear. Output is the last flop of the chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Chain registers; cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff_chain

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Turns a raw asynchronous PLL lock into a clean synchronous
//               reset and ready flag for one clock domain. Filters lock
//               chatter, enforces lock-stable and reset-hold intervals and
//               re-sequences on lock loss or software request.
//               Optional macro PLL_RESET_SEQ_LOSS_CNT_EN builds the
//               saturating lock-loss counter; otherwise lock_loss_cnt is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_CYCLES  = 1024,
    parameter int RESET_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             sw_rst_req,
    output logic             rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int            CW        = cnt_width(LOCK_CYCLES, RESET_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);

    logic          lock_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_out_q, rst_out_d;
    logic          ready_q, ready_d;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next-state logic: lock loss always takes priority over a software request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        // Outputs are derived from the next state so they flip on the same
        // edge as the state register rather than one cycle later.
        rst_out_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
    end

    // State, interval counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic             loss_evt;
    logic [CNT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;

    // Count lock drops seen while running, holding at all-ones.
    always_comb begin
        loss_evt        = (state_q == RUN) && !lock_s;
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (loss_evt && (lock_loss_cnt_q != '1)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + CNT_W'(1);
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_cnt_q <= '0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule : pll_reset_sequencer

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed self-checking bench for pll_reset_sequencer with
//               SYNC_STAGES=2, LOCK_CYCLES=4, RESET_CYCLES=3, CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       rst_out;
    logic       ready;
    logic [1:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int losses = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES  (2),
        .LOCK_CYCLES  (4),
        .RESET_CYCLES (3),
        .CNT_W        (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .sw_rst_req    (sw_rst_req),
        .rst_out       (rst_out),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected counter value after the recorded number of losses in RUN.
    function automatic logic [31:0] exp_loss();
        if (!CNT_EN) return 32'd0;
        return (losses > 3) ? 32'd3 : 32'(losses);
    endfunction

    // Relock from WAIT_LOCK and confirm the 9-edge deassert latency.
    task automatic relock(input string tag);
        pll_locked = 1'b1;
        tick(9);
        chk({tag, "_rst_k8"}, 32'(rst_out), 32'd1);
        tick(1);
        chk({tag, "_rst_k9"}, 32'(rst_out), 32'd0);
        chk({tag, "_rdy_k9"}, 32'(ready), 32'd1);
    endtask

    // Drop lock while running and confirm reset follows two edges later.
    task automatic drop_lock(input string tag);
        pll_locked = 1'b0;
        tick(2);
        chk({tag, "_rst_j1"}, 32'(rst_out), 32'd0);
        tick(1);
        losses++;
        chk({tag, "_rst_j2"}, 32'(rst_out), 32'd1);
        chk({tag, "_rdy_j2"}, 32'(ready), 32'd0);
        chk({tag, "_cnt"}, 32'(lock_loss_cnt), exp_loss());
    endtask

    initial begin
        reset_n    = 1'b1;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_rst", 32'(rst_out), 32'd1);
        chk("reset_rdy", 32'(ready), 32'd0);
        chk("reset_cnt", 32'(lock_loss_cnt), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("nolock_rst", 32'(rst_out), 32'd1);

        // Power-up sequence.
        relock("pwrup");

        // Lock loss in RUN, then relock.
        drop_lock("loss1");
        relock("relock1");

        // Chatter: single-cycle lock drop while STABILIZE cnt==2.
        drop_lock("loss2");
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("chatter_rst", 32'(rst_out), 32'd1);
        tick(7);
        chk("chatter_rst_k8", 32'(rst_out), 32'd1);
        tick(1);
        chk("chatter_rst_k9", 32'(rst_out), 32'd0);
        chk("chatter_rdy_k9", 32'(ready), 32'd1);

        // Software reset in RUN: three cycles of reset, counter unchanged.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        chk("sw_rst_c0", 32'(rst_out), 32'd1);
        chk("sw_rdy_c0", 32'(ready), 32'd0);
        tick(1);
        chk("sw_rst_c1", 32'(rst_out), 32'd1);
        tick(1);
        chk("sw_rst_c2", 32'(rst_out), 32'd1);
        tick(1);
        chk("sw_rst_c3", 32'(rst_out), 32'd0);
        chk("sw_rdy_c3", 32'(ready), 32'd1);
        chk("sw_cnt", 32'(lock_loss_cnt), exp_loss());

        // Lock loss and software request on the same edge: loss wins.
        pll_locked = 1'b0;
        tick(2);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        losses++;
        chk("simul_rst", 32'(rst_out), 32'd1);
        chk("simul_cnt", 32'(lock_loss_cnt), exp_loss());
        tick(12);
        chk("simul_stay", 32'(rst_out), 32'd1);

        // Software request in WAIT_LOCK is ignored.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        tick(2);
        chk("sw_wait_rst", 32'(rst_out), 32'd1);
        relock("sw_wait");

        // Two more losses drive the 2-bit counter into saturation.
        drop_lock("loss4");
        relock("relock4");
        drop_lock("loss5");
        relock("relock5");
        chk("sat_cnt", 32'(lock_loss_cnt), CNT_EN ? 32'd3 : 32'd0);

        // Asynchronous reset mid-HOLD, then full re-sequence.
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(8);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_rst", 32'(rst_out), 32'd1);
        chk("areset_rdy", 32'(ready), 32'd0);
        chk("areset_cnt", 32'(lock_loss_cnt), 32'd0);
        losses = 0;
        #1 reset_n = 1'b1;
        tick(9);
        chk("areset_rst_k8", 32'(rst_out), 32'd1);
        tick(1);
        chk("areset_rst_k9", 32'(rst_out), 32'd0);
        chk("areset_rdy_k9", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pll_reset_sequencer

`default_nettype wire
